// File: rtl/lanternfish_sequencer.sv
// lanternfish_sequencer: parses a comma-separated ASCII timer list into solver inserts, then advances the solver and captures its total.
module lanternfish_sequencer #(
  parameter int DAY_W = 9,
  parameter int SOL_W = 41
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DAY_W-1:0] days,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             solver_reset,
  output logic             insert,
  output logic [3:0]       value,
  output logic             advance,
  input  logic [SOL_W-1:0] solution,
  output logic [SOL_W-1:0] result,
  output logic             done,
  output logic             error
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_PARSE = 3'd2;
  localparam logic [2:0] S_ADV   = 3'd3;
  localparam logic [2:0] S_CAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;
  logic [2:0]       state_q, state_d;
  logic [DAY_W-1:0] cnt_q, cnt_d;
  logic [SOL_W-1:0] result_q, result_d;
  logic [3:0]       value_q, value_d;
  logic             insert_q, insert_d;
  logic             first_q, first_d;
  logic             dig_q, dig_d;
  logic             is_dig;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    value_d  = value_q;
    insert_d = 1'b0;
    first_d  = first_q;
    dig_d    = dig_q;
    is_dig   = (in_data >= 8'h30) && (in_data <= 8'h38);
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) begin
        cnt_d    = days;
        result_d = '0;
        state_d  = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_PARSE;
        first_d = 1'b1;
        dig_d   = 1'b0;
      end
      // first_q: nothing significant seen yet; dig_q: last significant byte was a digit
      S_PARSE: if (in_valid) begin
        if (is_dig && !dig_q) begin
          insert_d = 1'b1;
          value_d  = in_data[3:0];
          dig_d    = 1'b1;
          first_d  = 1'b0;
        end else if (in_data == 8'h2C && dig_q) begin
          dig_d   = 1'b0;
          first_d = 1'b0;
        end else if (in_data == 8'h0A && (first_q || dig_q)) begin
          state_d = (cnt_q == '0) ? S_CAP : S_ADV;
        end else if (in_data != 8'h0D) begin
          state_d = S_ERR;
        end
      end
      S_ADV: begin
        cnt_d   = cnt_q - DAY_W'(1);
        state_d = (cnt_q == DAY_W'(1)) ? S_CAP : S_ADV;
      end
      S_CAP: begin
        result_d = solution;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      value_q  <= '0;
      insert_q <= 1'b0;
      first_q  <= 1'b1;
      dig_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      value_q  <= value_d;
      insert_q <= insert_d;
      first_q  <= first_d;
      dig_q    <= dig_d;
    end
  end
  assign in_ready     = state_q == S_PARSE;
  assign solver_reset = state_q == S_CLEAR;
  assign advance      = state_q == S_ADV;
  assign done         = state_q == S_DONE;
  assign error        = state_q == S_ERR;
  assign insert       = insert_q;
  assign value        = value_q;
  assign result       = result_q;
endmodule

// File: tb/tb_lanternfish_sequencer.sv
// tb_lanternfish_sequencer: directed runs of the sequencer driving a behavioural lanternfish solver.
module tb_lanternfish_sequencer;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [8:0]  days = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready, solver_reset, insert, advance, done, error;
  logic [3:0]  value;
  logic [40:0] solution, result;
  logic [40:0] fish [16];
  logic [3:0]  ins_q [$];
  int          adv_n, n_cmp, n_err;
  bit          ov;

  lanternfish_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .days(days),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .solver_reset(solver_reset), .insert(insert), .value(value),
    .advance(advance), .solution(solution), .result(result),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always_comb begin
    solution = '0;
    for (int i = 0; i < 9; i++) solution = solution + fish[i];
  end

  always @(posedge clk) begin
    if (solver_reset) for (int i = 0; i < 16; i++) fish[i] <= '0;
    else if (insert) fish[value] <= fish[value] + 41'd1;
    else if (advance) begin
      for (int i = 0; i < 8; i++) fish[i] <= fish[i+1];
      fish[8] <= fish[0];
      fish[6] <= fish[7] + fish[0];
    end
  end

  always @(negedge clk) begin
    if (insert) ins_q.push_back(value);
    if (advance) adv_n++;
    if ((solver_reset && (insert || advance)) || (insert && advance)) ov = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_start(input int d);
    @(negedge clk);
    days = 9'(d);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ins_q.delete();
    adv_n = 0;
    ov = 1'b0;
    check("clear", solver_reset, 1);
    @(negedge clk);
    check("ready", in_ready, 1);
  endtask

  task automatic send(input string s, input bit rnd);
    for (int i = 0; i < s.len(); i++) begin
      int n = 0;
      if (error) break;
      if (rnd) while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = s[i];
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n == 20) begin
        check("accept_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_ok(input string s, input int d, input bit rnd, input string ei, input longint er);
    do_start(d);
    send(s, rnd);
    repeat (d) @(negedge clk);
    check("pre_done", done, 0);
    @(negedge clk);
    check("done", done, 1);
    check("result", result, er);
    check("adv_n", adv_n, d);
    check("error", error, 0);
    check("ins_n", ins_q.size(), ei.len());
    for (int i = 0; i < ei.len(); i++)
      check("ins_val", i < ins_q.size() ? 64'(ins_q[i]) : 64'd15, 64'(ei[i] - 8'h30));
    check("overlap", ov, 0);
  endtask

  initial begin
    int snap;
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_clr", solver_reset, 0);
    check("rst_adv", advance, 0);
    check("rst_ins", insert, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    check("rst_res", result, 0);
    @(negedge clk);
    reset = 1'b1;
    run_ok("3,4,3,1,2\n", 18, 0, "34312", 26);
    run_ok("3,4,3,1,2\n", 80, 1, "34312", 5934);
    run_ok("3,4,3,1,2\r\n", 256, 0, "34312", 64'd26984457539);
    do_start(5);
    send("3,,4\n", 0);
    check("err_set", error, 1);
    check("err_ready", in_ready, 0);
    check("err_done", done, 0);
    repeat (10) @(negedge clk);
    check("err_hold", error, 1);
    check("err_adv", adv_n, 0);
    check("err_ins_n", ins_q.size(), 1);
    check("err_ins_val", ins_q.size() > 0 ? 64'(ins_q[0]) : 64'd15, 3);
    run_ok("3,4,3,1,2\n", 18, 0, "34312", 26);
    run_ok("\n", 0, 0, "", 0);
    run_ok("8,0\n", 0, 0, "80", 2);
    do_start(100);
    send("3\n", 0);
    repeat (5) @(negedge clk);
    check("mid_adv", advance, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_adv", advance, 0);
    check("ar_ready", in_ready, 0);
    check("ar_done", done, 0);
    check("ar_res", result, 0);
    check("ar_ins", insert, 0);
    @(negedge clk);
    reset = 1'b1;
    snap = adv_n;
    repeat (10) @(negedge clk);
    check("post_adv", adv_n, snap);
    check("post_ready", in_ready, 0);
    check("post_clr", solver_reset, 0);
    check("post_done", done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/lanternfish_sequencer.md
Name: lanternfish_sequencer

Overview:
Front-end controller that drives the lanternfish counting solver. Accepts the puzzle input as an ASCII byte stream over a valid/ready handshake, parses comma-separated timer values, and issues one insert pulse per fish to the solver. Then issues the requested number of advance pulses, captures the solver's 41-bit total, and reports done or a parse error. It is the initiator side of the solver's clear/insert/advance/value/solution interface.

Parameters:
DAY_W, 9, width of days input and internal day down-counter (max 511 days)
SOL_W, 41, width of solver solution and captured result

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a run; honoured only in IDLE, DONE, ERROR
days  input  DAY_W  number of advance steps; sampled on accepted start
in_valid  input  1  input byte valid
in_data  input  8  ASCII input byte
in_ready  output  1  byte accepted when in_valid && in_ready
solver_reset  output  1  synchronous clear to solver, active-high
insert  output  1  add one fish with timer value
value  output  4  timer value for insert, 0..8
advance  output  1  advance solver one day
solution  input  SOL_W  solver total, combinational from solver counts
result  output  SOL_W  captured total
done  output  1  result valid; held until next start
error  output  1  illegal input seen; held until next start

Behaviour:
- Reset (reset=0, async): state IDLE, day counter 0; all outputs 0 (in_ready, solver_reset, insert, value, advance, result, done, error). Reset mid-run aborts immediately: advance/insert drop without waiting for clk.
- States: IDLE -> CLEAR -> PARSE -> ADVANCE -> CAPTURE -> DONE; PARSE -> ERROR.
- IDLE/DONE/ERROR: start=1 latches days, clears done/error/result, goes to CLEAR. start is ignored in all other states.
- CLEAR: exactly one cycle with solver_reset=1; then PARSE. solver_reset is never high in the same cycle as insert or advance.
- PARSE: in_ready=1. On an accepted byte:
  - '0'..'8': insert=1 and value=digit in the next cycle (registered, one-cycle pulse).
  - ',' (0x2C): separator.
  - 0x0D: ignored.
  - 0x0A: end of input; go to ADVANCE.
  - Anything else, including '9': go to ERROR.
- Grammar: a digit must be first or follow ','. ',' must follow a digit. 0x0A must be first (empty input) or follow a digit.
  - Two adjacent digits, leading ',', ",,", or ",\n" -> ERROR.
  - 0x0D does not change grammar context.
- The accept cycle for 0x0A may coincide with the insert pulse of the previous digit. The first advance is then one cycle later, so insert and advance are never simultaneous.
- ADVANCE: in_ready=0; advance=1 for exactly `days` consecutive cycles using the down-counter. With days=0 there are no pulses and the state passes through in one cycle.
- CAPTURE: one cycle after the last advance cycle; result <= solution. Next cycle: done=1, state DONE.
- Latency:
  - start in cycle 0: solver_reset in cycle 1; in_ready from cycle 2.
  - Byte accepted in cycle t: insert in cycle t+1.
  - 0x0A accepted in cycle t: advance in cycles t+1..t+days; done=1 from cycle t+days+2 (days=0: done at t+2).
- ERROR: error=1, in_ready=0, no further insert/advance, done=0; held until start or reset.
- DONE: result and done held stable; in_ready=0; further in_data is ignored.
- value holds the last inserted digit between pulses; its value is only meaningful while insert=1.
- No arithmetic beyond the day down-counter; result is a plain register copy of solution.

Test Plan:
- start with days=18, stream "3,4,3,1,2\n" with in_valid always high -> 5 insert pulses with values 3,4,3,1,2; 18 consecutive advance cycles; result=26; done=1.
- Same stream with days=80 and in_valid randomly deasserted -> insert sequence unchanged; 80 advance cycles; result=5934.
- days=256, stream "3,4,3,1,2\r\n" -> 0x0D ignored; result=26984457539; done=1, error=0.
- Stream "3,,4\n" -> error=1 one cycle after the second ',' is accepted; exactly one insert (value 3); no advance; in_ready=0; done=0. Then start with valid input -> error clears and the run completes.
- days=0 with "\n", then days=0 with "8,0\n" -> zero advance pulses both runs; results 0 and 2; the second run's solver_reset clears the first run's counts.
- Assert reset low mid-ADVANCE -> advance, done, result, in_ready go 0 immediately. After release: IDLE, no pulses until start.
